// File: rtl/wb_uart.sv
// wb_uart: Wishbone B3 classic 8N1 UART with TX/RX FIFOs, baud divider, sticky errors and level irq.
// Latency: ack one cycle after request; loopback routing is optional under WB_UART_LOOPBACK_EN.
// Backpressure: none on the bus; a full FIFO drops the byte and raises TXOVF/RXOVF.

// wb_uart_fifo: generic synchronous FIFO, head visible combinationally.
// Latency: push visible at head next cycle. Backpressure: push into full drops unless popped same cycle.
module wb_uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             wb_clk_i,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             empty,
    output logic             full,
    output logic             drop
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop & ~empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign do_push  = push & (~full | do_pop);
    assign drop     = push & ~do_push;
    assign head_dat = mem[rptr];

    always_ff @(posedge wb_clk_i) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (do_push) mem[wptr] <= push_dat;
    end
endmodule

module wb_uart #(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic        wb_clk_i,
    input  logic        rst,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    input  logic [3:0]  wbs_sel_i,
    input  logic        wbs_we_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic        uart_tx_o,
    input  logic        uart_rx_i,
    output logic        irq_o
);
    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;

    logic        ack_q, acc, bus_wr, bus_rd, stat_clr;
    logic [1:0]  reg_sel;
    logic [15:0] baud, baud_wdat;
    logic [2:0]  ctrl, ctrl_wdat;
    logic        txovf, rxovf, frerr, frerr_set, irq_q;
    logic [31:0] rd_dat;
    logic        unused_bits;

    logic        tx_push, tx_pop, tx_empty, tx_full, tx_drop, tx_load;
    logic [7:0]  tx_head;
    logic        rx_push, rx_pop, rx_empty, rx_full, rx_drop;
    logic [7:0]  rx_head;

    uart_state_t tx_state, tx_state_n;
    logic [15:0] tx_cnt, tx_cnt_n, tx_div, tx_div_n;
    logic [7:0]  tx_sh, tx_sh_n;
    logic [2:0]  tx_bit, tx_bit_n;
    logic        tx_line, tx_line_n, tx_busy;

    uart_state_t rx_state, rx_state_n;
    logic [15:0] rx_cnt, rx_cnt_n, rx_div, rx_div_n;
    logic [7:0]  rx_sh, rx_sh_n;
    logic [2:0]  rx_bit, rx_bit_n;
    logic        rx_pin, rx_s1, rx_s2, rx_prev;

    assign unused_bits = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i[31:16], wbs_sel_i[3:2]};

    assign reg_sel   = wbs_adr_i[3:2];
    assign acc       = ack_q & wbs_cyc_i & wbs_stb_i;
    assign bus_wr    = acc & wbs_we_i;
    assign bus_rd    = acc & ~wbs_we_i;
    assign tx_push   = bus_wr & (reg_sel == 2'd0) & wbs_sel_i[0];
    assign rx_pop    = bus_rd & (reg_sel == 2'd0);
    assign stat_clr  = bus_wr & (reg_sel == 2'd1);
    assign baud_wdat = {wbs_sel_i[1] ? wbs_dat_i[15:8] : baud[15:8],
                        wbs_sel_i[0] ? wbs_dat_i[7:0]  : baud[7:0]};
    assign tx_busy   = (tx_state != ST_IDLE);
    assign tx_pop    = tx_load;
    assign wbs_ack_o = ack_q;
    assign wbs_err_o = 1'b0;
    assign wbs_dat_o = ack_q ? rd_dat : 32'd0;
    assign irq_o     = irq_q;

`ifdef WB_UART_LOOPBACK_EN
    assign ctrl_wdat = wbs_dat_i[2:0];
    assign rx_pin    = ctrl[2] ? tx_line : uart_rx_i;
    assign uart_tx_o = ctrl[2] | tx_line;
`else
    assign ctrl_wdat = {1'b0, wbs_dat_i[1:0]};
    assign rx_pin    = uart_rx_i;
    assign uart_tx_o = tx_line;
`endif

    wb_uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .wb_clk_i(wb_clk_i), .rst(rst), .push(tx_push), .push_dat(wbs_dat_i[7:0]), .pop(tx_pop),
        .head_dat(tx_head), .empty(tx_empty), .full(tx_full), .drop(tx_drop)
    );

    wb_uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .wb_clk_i(wb_clk_i), .rst(rst), .push(rx_push), .push_dat(rx_sh), .pop(rx_pop),
        .head_dat(rx_head), .empty(rx_empty), .full(rx_full), .drop(rx_drop)
    );

    always_comb begin
        rd_dat = 32'd0;
        case (reg_sel)
            2'd0:    rd_dat = {23'd0, ~rx_empty, rx_empty ? 8'h00 : rx_head};
            2'd1:    rd_dat = {24'd0, tx_busy, frerr, rxovf, txovf, rx_full, ~rx_empty, tx_full, tx_empty};
            2'd2:    rd_dat = {16'd0, baud};
            default: rd_dat = {29'd0, ctrl};
        endcase
    end

    // Sticky flags: a new error event wins over a simultaneous write-1-to-clear.
    always_ff @(posedge wb_clk_i) begin
        if (rst) begin
            ack_q <= 1'b0;
            baud  <= DEFAULT_DIV;
            ctrl  <= 3'd0;
            txovf <= 1'b0;
            rxovf <= 1'b0;
            frerr <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            ack_q <= wbs_cyc_i & wbs_stb_i & ~ack_q;
            if (bus_wr && reg_sel == 2'd2 && |wbs_sel_i[1:0])
                baud <= (baud_wdat < 16'd3) ? 16'd3 : baud_wdat;
            if (bus_wr && reg_sel == 2'd3 && wbs_sel_i[0])
                ctrl <= ctrl_wdat;
            if (tx_drop)                        txovf <= 1'b1;
            else if (stat_clr && wbs_dat_i[4])  txovf <= 1'b0;
            if (rx_drop)                        rxovf <= 1'b1;
            else if (stat_clr && wbs_dat_i[5])  rxovf <= 1'b0;
            if (frerr_set)                      frerr <= 1'b1;
            else if (stat_clr && wbs_dat_i[6])  frerr <= 1'b0;
            irq_q <= (ctrl[0] & tx_empty) | (ctrl[1] & ~rx_empty) | frerr | rxovf;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (rst) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_div   <= '0;
            tx_sh    <= '0;
            tx_bit   <= '0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_div   <= tx_div_n;
            tx_sh    <= tx_sh_n;
            tx_bit   <= tx_bit_n;
            tx_line  <= tx_line_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_div_n   = tx_div;
        tx_sh_n    = tx_sh;
        tx_bit_n   = tx_bit;
        tx_load    = 1'b0;
        case (tx_state)
            ST_IDLE: tx_load = ~tx_empty;
            ST_START: begin
                if (tx_cnt == 16'd0) begin
                    tx_state_n = ST_DATA;
                    tx_cnt_n   = tx_div;
                    tx_bit_n   = 3'd0;
                end else tx_cnt_n = tx_cnt - 16'd1;
            end
            ST_DATA: begin
                if (tx_cnt == 16'd0) begin
                    tx_sh_n  = {1'b0, tx_sh[7:1]};
                    tx_bit_n = tx_bit + 3'd1;
                    tx_cnt_n = tx_div;
                    if (tx_bit == 3'd7) tx_state_n = ST_STOP;
                end else tx_cnt_n = tx_cnt - 16'd1;
            end
            default: begin
                if (tx_cnt == 16'd0) begin
                    if (!tx_empty) tx_load = 1'b1;
                    else           tx_state_n = ST_IDLE;
                end else tx_cnt_n = tx_cnt - 16'd1;
            end
        endcase
        // Divisor is captured per frame so BAUD writes never disturb a frame in flight.
        if (tx_load) begin
            tx_state_n = ST_START;
            tx_cnt_n   = baud;
            tx_div_n   = baud;
            tx_sh_n    = tx_head;
        end
        tx_line_n = 1'b1;
        if (tx_state_n == ST_START)     tx_line_n = 1'b0;
        else if (tx_state_n == ST_DATA) tx_line_n = tx_sh_n[0];
    end

    always_ff @(posedge wb_clk_i) begin
        if (rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= ST_IDLE;
            rx_cnt   <= '0;
            rx_div   <= '0;
            rx_sh    <= '0;
            rx_bit   <= '0;
        end else begin
            rx_s1    <= rx_pin;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_div   <= rx_div_n;
            rx_sh    <= rx_sh_n;
            rx_bit   <= rx_bit_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_div_n   = rx_div;
        rx_sh_n    = rx_sh;
        rx_bit_n   = rx_bit;
        rx_push    = 1'b0;
        frerr_set  = 1'b0;
        case (rx_state)
            ST_IDLE: begin
                if (rx_prev & ~rx_s2) begin
                    rx_state_n = ST_START;
                    rx_div_n   = baud;
                    // Half a bit period, (DIV+1)/2 clocks, counted from the edge cycle.
                    rx_cnt_n   = {1'b0, baud[15:1]} + {15'd0, baud[0]} - 16'd1;
                end
            end
            ST_START: begin
                if (rx_cnt == 16'd0) begin
                    if (rx_s2) rx_state_n = ST_IDLE;
                    else begin
                        rx_state_n = ST_DATA;
                        rx_cnt_n   = rx_div;
                        rx_bit_n   = 3'd0;
                    end
                end else rx_cnt_n = rx_cnt - 16'd1;
            end
            ST_DATA: begin
                if (rx_cnt == 16'd0) begin
                    rx_sh_n  = {rx_s2, rx_sh[7:1]};
                    rx_bit_n = rx_bit + 3'd1;
                    rx_cnt_n = rx_div;
                    if (rx_bit == 3'd7) rx_state_n = ST_STOP;
                end else rx_cnt_n = rx_cnt - 16'd1;
            end
            default: begin
                if (rx_cnt == 16'd0) begin
                    rx_state_n = ST_IDLE;
                    if (rx_s2) rx_push   = 1'b1;
                    else       frerr_set = 1'b1;
                end else rx_cnt_n = rx_cnt - 16'd1;
            end
        endcase
    end
endmodule

// File: tb/tb_wb_uart.sv
// Bench for wb_uart: register vector table, TX line monitor with byte scoreboard, RX driver with scoreboard.
module tb_wb_uart;
    logic        wb_clk_i = 1'b0;
    logic        rst;
    logic [31:0] wbs_adr_i, wbs_dat_i, wbs_dat_o;
    logic [3:0]  wbs_sel_i;
    logic        wbs_we_i, wbs_cyc_i, wbs_stb_i, wbs_ack_o, wbs_err_o;
    logic        uart_tx_o, uart_rx_i, irq_o;

    wb_uart dut (
        .wb_clk_i(wb_clk_i), .rst(rst), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_dat_o(wbs_dat_o), .wbs_sel_i(wbs_sel_i), .wbs_we_i(wbs_we_i), .wbs_cyc_i(wbs_cyc_i),
        .wbs_stb_i(wbs_stb_i), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o),
        .uart_tx_o(uart_tx_o), .uart_rx_i(uart_rx_i), .irq_o(irq_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

`ifdef WB_UART_LOOPBACK_EN
    localparam logic [31:0] CTRL_RB = 32'h7;
`else
    localparam logic [31:0] CTRL_RB = 32'h3;
`endif

    typedef struct packed {
        logic        we;
        logic [3:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp;
        logic        exp_irq;
    } vec_t;

    vec_t        vecs [20];
    int          checks = 0;
    int          failures = 0;
    int          tb_div = 433;
    int          tx_frames = 0;
    bit          mon_en = 1'b1;
    logic [7:0]  txq [$];
    logic [31:0] rxq [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wb_xfer(input logic w, input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd);
        bit got;
        got = 1'b0;
        rd = 32'd0;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = w;
        wbs_adr_i = {28'd0, a}; wbs_dat_i = d; wbs_sel_i = s;
        for (int i = 0; i < 8; i++) begin
            @(posedge wb_clk_i); #1;
            if (wbs_ack_o) begin
                got = 1'b1;
                rd = wbs_dat_o;
                break;
            end
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL wb_ack_timeout: no ack for adr 0x%0h within 8 cycles, ack required", a);
        end else begin
            @(posedge wb_clk_i); #1;
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    endtask

    task automatic wb_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] dummy;
        wb_xfer(1'b1, a, d, s, dummy);
    endtask

    task automatic rd_check(input string name, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        wb_xfer(1'b0, a, 32'd0, 4'hF, rd);
        check(name, rd, exp);
    endtask

    task automatic rx_read_check(input string name);
        logic [31:0] rd, exp;
        exp = (rxq.size() != 0) ? rxq.pop_front() : 32'd0;
        wb_xfer(1'b0, 4'h0, 32'd0, 4'hF, rd);
        check(name, rd, exp);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stopv, input int div);
        logic v;
        for (int i = 0; i < 10; i++) begin
            v = (i == 0) ? 1'b0 : (i == 9) ? stopv : b[i-1];
            uart_rx_i = v;
            repeat (div + 1) @(posedge wb_clk_i);
            #1;
        end
        uart_rx_i = 1'b1;
    endtask

    task automatic wait_frames(input int n, input int budget, input string name);
        for (int i = 0; i < budget && tx_frames < n; i++) begin
            @(posedge wb_clk_i); #1;
        end
        check(name, 32'(tx_frames >= n), 32'd1);
    endtask

    task automatic irq_check(input string name, input logic exp);
        @(posedge wb_clk_i); #1;
        check(name, {31'd0, irq_o}, {31'd0, exp});
    endtask

    // TX line monitor: samples every clock of a frame, requiring each bit steady for DIV+1 clocks.
    initial begin
        int         per;
        logic [9:0] bits;
        logic       steady;
        forever begin
            @(posedge wb_clk_i); #1;
            if (mon_en && !rst && uart_tx_o === 1'b0) begin
                per = tb_div + 1;
                steady = 1'b1;
                bits = '0;
                for (int k = 0; k < 10 * per; k++) begin
                    if (k > 0) begin @(posedge wb_clk_i); #1; end
                    if (k % per == 0) bits[k / per] = uart_tx_o;
                    else if (uart_tx_o !== bits[k / per]) steady = 1'b0;
                end
                check("tx_frame_shape{steady,start,stop}", {29'd0, steady, bits[0], bits[9]}, 32'h5);
                if (txq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL tx_unexpected_frame: got byte 0x%02h, no frame expected", bits[8:1]);
                end else begin
                    check("tx_frame_byte", {24'd0, bits[8:1]}, {24'd0, txq.pop_front()});
                end
                tx_frames++;
            end
        end
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic lowseen;
        vecs[0]  = '{1'b0, 4'h4, 32'h0,         4'hF, 32'h1,    1'b0};
        vecs[1]  = '{1'b0, 4'h8, 32'h0,         4'hF, 32'd433,  1'b0};
        vecs[2]  = '{1'b0, 4'hC, 32'h0,         4'hF, 32'h0,    1'b0};
        vecs[3]  = '{1'b0, 4'h0, 32'h0,         4'hF, 32'h0,    1'b0};
        vecs[4]  = '{1'b1, 4'h8, 32'h1,         4'hF, 32'h0,    1'b0};
        vecs[5]  = '{1'b0, 4'h8, 32'h0,         4'hF, 32'h3,    1'b0};
        vecs[6]  = '{1'b1, 4'h8, 32'hFFFF_0007, 4'h1, 32'h0,    1'b0};
        vecs[7]  = '{1'b0, 4'h8, 32'h0,         4'hF, 32'h7,    1'b0};
        vecs[8]  = '{1'b1, 4'h8, 32'h0000_0500, 4'h2, 32'h0,    1'b0};
        vecs[9]  = '{1'b0, 4'h8, 32'h0,         4'hF, 32'h507,  1'b0};
        vecs[10] = '{1'b1, 4'hC, 32'h7,         4'hF, 32'h0,    1'b1};
        vecs[11] = '{1'b0, 4'hC, 32'h0,         4'hF, CTRL_RB,  1'b1};
        vecs[12] = '{1'b1, 4'hC, 32'h0,         4'h0, 32'h0,    1'b1};
        vecs[13] = '{1'b0, 4'hC, 32'h0,         4'hF, CTRL_RB,  1'b1};
        vecs[14] = '{1'b1, 4'hC, 32'h0,         4'hF, 32'h0,    1'b0};
        vecs[15] = '{1'b0, 4'hC, 32'h0,         4'hF, 32'h0,    1'b0};
        vecs[16] = '{1'b1, 4'h8, 32'h3,         4'hF, 32'h0,    1'b0};
        vecs[17] = '{1'b0, 4'h8, 32'h0,         4'hF, 32'h3,    1'b0};
        vecs[18] = '{1'b1, 4'h4, 32'h70,        4'hF, 32'h0,    1'b0};
        vecs[19] = '{1'b0, 4'h4, 32'h0,         4'hF, 32'h1,    1'b0};

        rst = 1'b1; uart_rx_i = 1'b1;
        wbs_adr_i = '0; wbs_dat_i = '0; wbs_sel_i = '0;
        wbs_we_i = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        repeat (3) @(posedge wb_clk_i);
        #1;
        check("reset_ack", {31'd0, wbs_ack_o}, 32'd0);
        check("reset_dat_o", wbs_dat_o, 32'd0);
        check("reset_tx", {31'd0, uart_tx_o}, 32'd1);
        check("reset_irq", {31'd0, irq_o}, 32'd0);
        check("reset_err", {31'd0, wbs_err_o}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            logic [31:0] rd;
            wb_xfer(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, rd);
            if (!vecs[i].we) check($sformatf("vec%0d_rdat", i), rd, vecs[i].exp);
            irq_check($sformatf("vec%0d_irq", i), vecs[i].exp_irq);
        end
        tb_div = 3;

        // Single 0xA5 frame at DIV=3 with TXBUSY observed mid-frame.
        txq.push_back(8'hA5);
        wb_write(4'h0, 32'hA5, 4'h1);
        repeat (8) @(posedge wb_clk_i);
        #1;
        rd_check("a5_status_busy", 4'h4, 32'h81);
        wait_frames(1, 100, "a5_frame_done");
        rd_check("a5_status_end", 4'h4, 32'h01);

        // Ten back-to-back writes: nine fit (one in the FSM, eight queued), the tenth overflows.
        for (int i = 0; i < 10; i++) begin
            if (i < 9) txq.push_back(8'(8'h30 + i));
            wb_write(4'h0, 32'(8'h30 + i), 4'h1);
        end
        rd_check("burst_status_ovf", 4'h4, 32'h92);
        wb_write(4'h4, 32'h10, 4'hF);
        rd_check("burst_status_clr", 4'h4, 32'h82);
        irq_check("burst_irq", 1'b0);
        wait_frames(10, 500, "burst_frames_done");
        rd_check("burst_status_end", 4'h4, 32'h01);

        // RX at DIV=7: good frame, then a framing error.
        wb_write(4'h8, 32'h7, 4'hF);
        tb_div = 7;
        rxq.push_back(32'h13C);
        send_rx(8'h3C, 1'b1, 7);
        rx_read_check("rx_3c_data");
        rd_check("rx_3c_status", 4'h4, 32'h01);
        send_rx(8'h55, 1'b0, 7);
        rd_check("frerr_status", 4'h4, 32'h41);
        check("frerr_irq", {31'd0, irq_o}, 32'd1);
        rx_read_check("frerr_no_data");
        wb_write(4'h4, 32'h40, 4'hF);
        irq_check("frerr_irq_clr", 1'b0);
        rd_check("frerr_status_clr", 4'h4, 32'h01);

        // Nine frames unread: eight stored, ninth dropped with RXOVF.
        for (int i = 0; i < 9; i++) begin
            if (i < 8) rxq.push_back(32'h100 | 32'(8'h41 + i));
            send_rx(8'(8'h41 + i), 1'b1, 7);
        end
        rd_check("rxovf_status", 4'h4, 32'h2D);
        check("rxovf_irq", {31'd0, irq_o}, 32'd1);
        for (int i = 0; i < 8; i++) rx_read_check($sformatf("rxovf_read%0d", i));
        rd_check("rxovf_status_drained", 4'h4, 32'h21);
        wb_write(4'h4, 32'h20, 4'hF);
        irq_check("rxovf_irq_clr", 1'b0);
        rd_check("rxovf_status_clr", 4'h4, 32'h01);

        // Two-clock low glitch must not start a frame.
        uart_rx_i = 1'b0;
        repeat (2) @(posedge wb_clk_i);
        #1;
        uart_rx_i = 1'b1;
        repeat (100) @(posedge wb_clk_i);
        #1;
        rd_check("glitch_status", 4'h4, 32'h01);
        rx_read_check("glitch_no_data");

`ifdef WB_UART_LOOPBACK_EN
        wb_write(4'hC, 32'h4, 4'hF);
        rxq.push_back(32'h15A);
        wb_write(4'h0, 32'h5A, 4'h1);
        lowseen = 1'b0;
        repeat (120) begin
            @(posedge wb_clk_i); #1;
            if (uart_tx_o !== 1'b1) lowseen = 1'b1;
        end
        check("loop_tx_held_high", {31'd0, lowseen}, 32'd0);
        rx_read_check("loop_rx_data");
        wb_write(4'hC, 32'h0, 4'hF);
`endif

        // Reset in the middle of an all-zero frame returns the line high immediately.
        mon_en = 1'b0;
        wb_write(4'h0, 32'h00, 4'h1);
        repeat (12) @(posedge wb_clk_i);
        #1;
        check("midframe_tx_low", {31'd0, uart_tx_o}, 32'd0);
        rst = 1'b1;
        @(posedge wb_clk_i); #1;
        check("midframe_reset_tx", {31'd0, uart_tx_o}, 32'd1);
        rst = 1'b0;
        rd_check("midframe_reset_status", 4'h4, 32'h01);
        rd_check("midframe_reset_baud", 4'h8, 32'd433);

        check("txq_drained", 32'(txq.size()), 32'd0);
        check("rxq_drained", 32'(rxq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_uart.md
Name: wb_uart

Overview:
- Wishbone B3 classic slave UART (8N1) that attaches as a target port of the payload's Wishbone interconnect, next to the SRAM target.
- Gives the RV32I core and the management SoC a serial console on two user IO pads.
- Contains TX and RX FIFOs, a programmable baud divider, sticky error flags and a level interrupt.
- Registers are word-addressed using wbs_adr_i[3:2]; upper address bits are decoded by the interconnect and ignored here.

Parameters:
- FIFO_DEPTH, 8, entries in each of the TX and RX FIFOs; power of two, 2..16.
- DEFAULT_DIV, 16'd433, reset value of the BAUD register. Bit period = DIV+1 clocks.

Ports:
- wb_clk_i  in  1  system clock.
- rst  in  1  reset.
- wbs_adr_i  in  32  byte address; only [3:2] used.
- wbs_dat_i  in  32  write data.
- wbs_dat_o  out  32  read data.
- wbs_sel_i  in  4  byte enables.
- wbs_we_i  in  1  write enable.
- wbs_cyc_i  in  1  bus cycle.
- wbs_stb_i  in  1  strobe.
- wbs_ack_o  out  1  acknowledge.
- wbs_err_o  out  1  error, tied 0.
- uart_tx_o  out  1  serial out, idle high.
- uart_rx_i  in  1  serial in, asynchronous.
- irq_o  out  1  level interrupt.

Behaviour:
- Reset: rst is synchronous, active-high; clock is wb_clk_i.
  - On reset: wbs_ack_o=0, wbs_dat_o=0, uart_tx_o=1, irq_o=0.
  - Both FIFOs empty, all sticky flags 0, CTRL=0, BAUD=DEFAULT_DIV, both FSMs IDLE.
  - Reset mid-frame aborts the frame; uart_tx_o is 1 in the cycle after rst is sampled.
- Wishbone handshake:
  - wbs_ack_o is registered and asserts for exactly 1 cycle, the cycle after cyc&stb&~ack.
  - Side effects (push/pop/clear) take effect on the ack cycle.
  - Back-to-back accesses therefore complete every 2 cycles.
  - wbs_dat_o is valid on the ack cycle and 0 otherwise.
- Register map:
  - 0x0 DATA.
    - Write with sel[0] pushes dat_i[7:0] to the TX FIFO. If the FIFO is full, the byte is dropped and TXOVF is set.
    - Read returns {23'b0, rx_nonempty, rx_head[7:0]} and pops the RX FIFO if it is non-empty. Reading an empty FIFO returns 0 with no pop.
  - 0x4 STATUS (read).
    - bit0 TXEMPTY, bit1 TXFULL, bit2 RXVALID, bit3 RXFULL.
    - bit4 TXOVF, bit5 RXOVF, bit6 FRERR.
    - bit7 TXBUSY (TX FSM not in IDLE).
    - Write-1-to-clear bits 6:4; other bits are ignored on write.
  - 0x8 BAUD.
    - [15:0] divisor; writes with value <3 are stored as 3.
    - The TX/RX FSMs latch the divisor at each frame start, so a change mid-frame applies to the next frame.
  - 0xC CTRL.
    - bit0 TXIE, bit1 RXIE, bit2 LOOP (see Optional Feature).
  - Writes honour sel for BAUD/CTRL byte lanes.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE pops the FIFO head when non-empty and goes to START the next cycle.
  - Each state lasts DIV+1 clocks; DATA shifts 8 bits LSB first; STOP drives 1.
  - From STOP, goes directly to START if the FIFO is non-empty, with no idle gap.
- RX path:
  - uart_rx_i passes through a 2-flop synchroniser.
  - IDLE: a falling edge goes to START.
  - START: samples at (DIV+1)/2 clocks. If the line is high (glitch), return to IDLE; else go to DATA.
  - DATA: samples each bit at its midpoint (every DIV+1 clocks), LSB first.
  - STOP: samples the midpoint of the stop bit.
    - If 0: set FRERR and discard the byte.
    - Else: push the byte; if RX FIFO is full, drop the byte and set RXOVF.
  - Simultaneous pop-by-read and push on a full RX FIFO: both succeed, no overflow.
  - Simultaneous TX pop by FSM and DATA write on a full TX FIFO: push accepted.
- FIFO pointers wrap modulo FIFO_DEPTH; the count is log2(FIFO_DEPTH)+1 bits.
- irq_o (registered) = (TXIE & TXEMPTY) | (RXIE & RXVALID) | FRERR | RXOVF.

Optional Feature:
- Macro WB_UART_LOOPBACK_EN.
- Defined:
  - CTRL.LOOP=1 routes the internal TX serial line to the RX synchroniser input in place of uart_rx_i.
  - uart_tx_o is held at 1 while LOOP=1.
- Undefined:
  - CTRL bit2 is read-only 0 and writes to it are ignored.
  - RX always uses uart_rx_i.

Test Plan:
- Reset, then read 0x4 -> 0x00000001; read 0x8 -> 433; uart_tx_o=1; irq_o=0.
- Write BAUD=3, write DATA=0xA5 -> uart_tx_o emits the bits 0,1,0,1,0,0,1,0,1,1, each 4 clocks (40-clock frame); TXBUSY during the frame; TXEMPTY=1 at the end.
- Write BAUD=1 -> read back 3. Write 9 bytes back-to-back with no drain, FIFO_DEPTH=8 and the first byte already popped into the TX FSM -> 9 bytes accepted. The 10th write sets TXOVF; W1C of 0x10 clears it.
- Drive an RX frame 0x3C at DIV=7, then read DATA -> 0x13C and RXVALID clears. Drive a frame with stop=0 -> FRERR=1, no data pushed, irq_o=1.
- Send 9 RX bytes without reading -> RXFULL; the 9th byte is dropped and RXOVF set; 8 reads return bytes 1..8 in order.
- WB_UART_LOOPBACK_EN defined, LOOP=1, write 0x5A -> RX FIFO receives 0x5A and uart_tx_o stays 1. A 2-clock low glitch on uart_rx_i with DIV=7 produces no data.
